// File: rtl/mio_pkg.sv
// Shared types and address-decode helper for the MIO bus responder.
// Latency: none (types, constants and a pure function only).
// Backpressure: not applicable.
// Optional feature macro: MIO_TIMER_EN (enables decode of the TIMER register).
package mio_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    typedef enum logic [2:0] {
        RGN_RAM   = 3'd0,
        RGN_LED   = 3'd1,
        RGN_SW    = 3'd2,
        RGN_TIMER = 3'd3,
        RGN_NONE  = 3'd4
    } region_t;

    // Byte offsets of the IO registers inside the IO region.
    localparam logic [27:0] LED_OFS   = 28'h000_0000;
    localparam logic [27:0] SW_OFS    = 28'h000_0004;
    localparam logic [27:0] TIMER_OFS = 28'h000_0008;

    // Classify a CPU byte address. The two byte-select bits are masked off
    // so any byte address inside a word hits that word.
    function automatic region_t decode_region(input logic [31:0] addr,
                                              input logic [3:0]  io_nib,
                                              input int unsigned ram_words);
        logic [27:0] ofs;
        region_t     rgn;
        ofs = addr[27:0] & 28'hFFF_FFFC;
        rgn = RGN_NONE;
        if (addr[31:28] == io_nib) begin
            if (ofs == LED_OFS) begin
                rgn = RGN_LED;
            end else if (ofs == SW_OFS) begin
                rgn = RGN_SW;
            end
`ifdef MIO_TIMER_EN
            else if (ofs == TIMER_OFS) begin
                rgn = RGN_TIMER;
            end
`endif
        end else if ((addr >> 2) < ram_words) begin
            rgn = RGN_RAM;
        end
        return rgn;
    endfunction

endpackage

// File: rtl/mio_ram.sv
// Single-port synchronous word RAM (WORDS x 32); write and read on the rising edge.
// Latency: rdata reflects addr one cycle later; a simultaneous write returns the old word.
// Backpressure: none, accepts an access every cycle.
// Ports: clk, we (write enable), addr (word index), wdata, rdata (registered).
module mio_ram #(
    parameter int WORDS = 1024,
    parameter int AW    = $clog2(WORDS)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);

    logic [31:0] mem [WORDS];
    logic [31:0] rdata_q;

    // Contents are deliberately not reset; software must initialise RAM.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
        rdata_q <= mem[addr];
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/mio_bus_responder.sv
// MIO bus responder: RAM + LED/SW(/TIMER) IO registers behind a wait-state FSM.
// Latency: MIO_ready pulses for one cycle WAIT_CYCLES cycles after the accepting edge (IDLE->WAIT->RESP).
// Backpressure: CPU holds CPU_MIO and request fields until MIO_ready; dropping CPU_MIO in WAIT aborts.
// Ports: clk/rst (async active-low); CPU side CPU_MIO, MemRW, Addr_out, Data_out, Data_in, MIO_ready;
//        board side sw_in, led_out; bus_err is a sticky unmapped-access flag.
// Optional feature macro: MIO_TIMER_EN (free-running 32-bit cycle counter at IO_BASE+0x8).
module mio_bus_responder
    import mio_pkg::*;
#(
    parameter int          RAM_WORDS   = 1024,
    parameter int          WAIT_CYCLES = 1,
    parameter logic [31:0] IO_BASE     = 32'hF000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        CPU_MIO,
    input  logic        MemRW,
    input  logic [31:0] Addr_out,
    input  logic [31:0] Data_out,
    output logic [31:0] Data_in,
    output logic        MIO_ready,
    input  logic [15:0] sw_in,
    output logic [15:0] led_out,
    output logic        bus_err
);

    localparam int AW = $clog2(RAM_WORDS);

    state_t        state_q, state_d;
    logic [3:0]    cnt_q, cnt_d;
    logic          rw_q, rw_d;
    region_t       region_q, region_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [31:0]   wdata_q, wdata_d;
    logic [31:0]   data_hold_q, data_hold_d;
    logic [15:0]   led_q, led_d;
    logic [15:0]   sw_s1_q, sw_s2_q;
    logic          bus_err_q, bus_err_d;

    logic          accept;
    logic          resp;
    logic          ram_we;
    logic [AW-1:0] ram_addr;
    logic [31:0]   ram_rdata;
    logic [31:0]   rd_mux;

`ifdef MIO_TIMER_EN
    logic [31:0]   timer_q, timer_d;
`endif

    assign accept = (state_q == IDLE) && CPU_MIO;

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (CPU_MIO) begin
                    state_d = (WAIT_CYCLES == 0) ? RESP : WAIT;
                end
            end
            WAIT: begin
                if (!CPU_MIO) begin
                    state_d = IDLE;
                end else if (cnt_q <= 4'd1) begin
                    state_d = RESP;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        resp      = (state_q == RESP);
        MIO_ready = resp;
        ram_we    = resp && rw_q && (region_q == RGN_RAM);
        // In IDLE the live address feeds the RAM so a zero-wait read still
        // has its data registered by the time RESP is entered.
        ram_addr  = (state_q == IDLE) ? Addr_out[AW+1:2] : addr_q;
        case (region_q)
            RGN_RAM:   rd_mux = ram_rdata;
            RGN_LED:   rd_mux = {16'h0000, led_q};
            RGN_SW:    rd_mux = {16'h0000, sw_s2_q};
`ifdef MIO_TIMER_EN
            RGN_TIMER: rd_mux = timer_q;
`endif
            default:   rd_mux = 32'h0000_0000;
        endcase
        if (resp) begin
            Data_in = rw_q ? 32'h0000_0000 : rd_mux;
        end else begin
            Data_in = data_hold_q;
        end
        led_out = led_q;
        bus_err = bus_err_q;
    end

    // ---------------- datapath next-state ----------------
    always_comb begin
        cnt_d       = cnt_q;
        rw_d        = rw_q;
        region_d    = region_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        data_hold_d = data_hold_q;
        led_d       = led_q;
        bus_err_d   = bus_err_q;
        if (accept) begin
            cnt_d    = 4'(WAIT_CYCLES);
            rw_d     = MemRW;
            region_d = decode_region(Addr_out, IO_BASE[31:28], RAM_WORDS);
            addr_d   = Addr_out[AW+1:2];
            wdata_d  = Data_out;
        end else if (state_q == WAIT) begin
            cnt_d = cnt_q - 4'd1;
        end
        // Side effects commit on the edge leaving RESP, so a reset that
        // lands before that edge discards the transaction completely.
        if (resp) begin
            data_hold_d = Data_in;
            if (rw_q && (region_q == RGN_LED)) begin
                led_d = wdata_q[15:0];
            end
            if (region_q == RGN_NONE) begin
                bus_err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q       <= 4'd0;
            rw_q        <= 1'b0;
            region_q    <= RGN_NONE;
            addr_q      <= '0;
            wdata_q     <= 32'h0000_0000;
            data_hold_q <= 32'h0000_0000;
            led_q       <= 16'h0000;
            sw_s1_q     <= 16'h0000;
            sw_s2_q     <= 16'h0000;
            bus_err_q   <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            rw_q        <= rw_d;
            region_q    <= region_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            data_hold_q <= data_hold_d;
            led_q       <= led_d;
            sw_s1_q     <= sw_in;
            sw_s2_q     <= sw_s1_q;
            bus_err_q   <= bus_err_d;
        end
    end

`ifdef MIO_TIMER_EN
    always_comb begin
        timer_d = timer_q + 32'd1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            timer_q <= 32'h0000_0000;
        end else begin
            timer_q <= timer_d;
        end
    end
`endif

    mio_ram #(
        .WORDS (RAM_WORDS)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .addr  (ram_addr),
        .wdata (wdata_q),
        .rdata (ram_rdata)
    );

endmodule
